// File: rtl/backprop_pkg.sv
// backprop_pkg
// Shared helpers for the backprop systolic stack.
//   lane(vec, dw, n, k) : element k of an n-lane packed vector of dw-bit lanes.
//                         Lane 0 is the MSB slice, so this returns
//                         vec[dw*(n-k)-1 -: dw], zero-extended to MAX_LANE_W.
//   cnt_w(rows)         : width of a counter holding 0..rows-1 (at least 1).
package backprop_pkg;

  localparam int unsigned MAX_LANE_W = 64;
  localparam int unsigned MAX_VEC_W  = 1024;

  function automatic logic [MAX_LANE_W-1:0] lane(
    input logic [MAX_VEC_W-1:0] vec,
    input int unsigned          dw,
    input int unsigned          n,
    input int unsigned          k
  );
    logic [MAX_LANE_W-1:0] mask;
    mask = {MAX_LANE_W{1'b1}} >> (MAX_LANE_W - dw);
    // Lane k's LSB sits (n-1-k) lanes above bit 0.
    return MAX_LANE_W'(vec >> (dw * (n - 1 - k))) & mask;
  endfunction

  function automatic int cnt_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/lane_delay.sv
// lane_delay
// depth-stage shift register carrying {valid, data} for one lane.
// Every stage shifts on every clock; there is no enable.
// depth = 0 makes the block a plain wire.
// Ports:
//   clk, reset (async, active-high), clear (sync flush of all stages)
//   in_valid/in_data   : lane input
//   out_valid/out_data : lane input delayed by depth cycles
module lane_delay #(
  parameter int data_size = 16,
  parameter int depth     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [data_size-1:0] in_data,
  output logic                 out_valid,
  output logic [data_size-1:0] out_data
);

  generate
    if (depth == 0) begin : g_pass
      logic w_unused;
      assign w_unused  = ^{clk, reset, clear};
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_shift
      logic [data_size:0] r_stage [depth];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < depth; i++) r_stage[i] <= '0;
        end else if (clear) begin
          for (int i = 0; i < depth; i++) r_stage[i] <= '0;
        end else begin
          r_stage[0] <= {in_valid, in_data};
          for (int i = 1; i < depth; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign out_valid = r_stage[depth-1][data_size];
      assign out_data  = r_stage[depth-1][data_size-1:0];
    end
  endgenerate

endmodule

// File: rtl/deskew_collector.sv
// deskew_collector
// Realigns diagonally skewed per-lane results (lane k arrives k cycles after
// lane 0) into one parallel vector per row, counts rows into frames and
// flags rows whose lanes do not line up.
// Ports:
//   clk, reset (async, active-high), clear (sync flush)
//   in_valid[size]   : bit size-1-k is lane k's valid
//   in_data          : lane k at [data_size*(size-k)-1 -: data_size]
//   out_valid        : aligned row on out_data
//   out_data         : aligned row, same packing as in_data
//   frame_done       : pulse with the last row (row_index = rows-1) of a frame
//   row_index        : row number of the vector on out_data
//   misalign_err     : sticky, set when lanes arrive with mixed valids
module deskew_collector
  import backprop_pkg::*;
#(
  parameter int data_size = 16,
  parameter int size      = 3,
  parameter int rows      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [size-1:0]             in_valid,
  input  logic [data_size*size-1:0]   in_data,
  output logic                        out_valid,
  output logic [data_size*size-1:0]   out_data,
  output logic                        frame_done,
  output logic [cnt_w(rows)-1:0]      row_index,
  output logic                        misalign_err
);

  localparam int RW = cnt_w(rows);

  logic [size-1:0]           w_al_valid;
  logic [data_size-1:0]      w_al_data [size];
  logic [data_size*size-1:0] w_al_vec;
  logic                      w_all;
  logic                      w_any;

  logic                      r_out_valid;
  logic [data_size*size-1:0] r_out_data;
  logic                      r_frame_done;
  logic [RW-1:0]             r_row_index;
  logic [RW-1:0]             r_cnt;
  logic                      r_err;

  genvar gi;
  generate
    for (gi = 0; gi < size; gi++) begin : g_lane
      logic [data_size-1:0] w_lane_in;
      assign w_lane_in = data_size'(lane(MAX_VEC_W'(in_data), data_size, size, gi));

      // Early lanes wait longest so that all lanes of a row meet together.
      lane_delay #(
        .data_size (data_size),
        .depth     (size - 1 - gi)
      ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid[size-1-gi]),
        .in_data   (w_lane_in),
        .out_valid (w_al_valid[gi]),
        .out_data  (w_al_data[gi])
      );

      assign w_al_vec[data_size*(size-gi)-1 -: data_size] = w_al_data[gi];
    end
  endgenerate

  assign w_all = &w_al_valid;
  assign w_any = |w_al_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
      r_row_index  <= '0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else if (clear) begin
      // Clear beats a row completing on the same edge; out_data keeps its value.
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_out_valid  <= w_all;
      r_frame_done <= w_all && (r_cnt == RW'(rows - 1));
      if (w_all) begin
        r_out_data  <= w_al_vec;
        r_row_index <= r_cnt;
        r_cnt       <= (r_cnt == RW'(rows - 1)) ? '0 : r_cnt + 1'b1;
      end
      // Mixed valids: the row is dropped and the error latches.
      if (w_any && !w_all) r_err <= 1'b1;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign frame_done   = r_frame_done;
  assign row_index    = r_row_index;
  assign misalign_err = r_err;

endmodule

// File: tb/tb_deskew_collector.sv
module tb_deskew_collector;

  logic        clk;
  logic        reset;
  logic        clear;

  // Main instance: data_size=16, size=3, rows=4
  logic [2:0]  in_valid;
  logic [47:0] in_data;
  logic        out_valid;
  logic [47:0] out_data;
  logic        frame_done;
  logic [1:0]  row_index;
  logic        misalign_err;

  // Small instance: data_size=16, size=2, rows=1
  logic [1:0]  in_valid2;
  logic [31:0] in_data2;
  logic        out_valid2;
  logic [31:0] out_data2;
  logic        frame_done2;
  logic [0:0]  row_index2;
  logic        misalign_err2;

  int tests_run = 0;
  int tests_failed = 0;

  deskew_collector #(.data_size(16), .size(3), .rows(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .frame_done   (frame_done),
    .row_index    (row_index),
    .misalign_err (misalign_err)
  );

  deskew_collector #(.data_size(16), .size(2), .rows(1)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .in_valid     (in_valid2),
    .in_data      (in_data2),
    .out_valid    (out_valid2),
    .out_data     (out_data2),
    .frame_done   (frame_done2),
    .row_index    (row_index2),
    .misalign_err (misalign_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane 0 is the MSB slice; valid bit 2 belongs to lane 0.
  task automatic drv(input logic [2:0] v, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] c);
    in_valid = v;
    in_data  = {a, b, c};
  endtask

  task automatic chk_row(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [1:0] idx, input logic fd);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  64'(out_data), 64'({a, b, c}));
    chk({tag, "_idx"},   64'(row_index), 64'(idx));
    chk({tag, "_fd"},    64'(frame_done), 64'(fd));
    $display("[TB] row %s: data=%0h idx=%0d fd=%0b", tag, out_data, row_index, frame_done);
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    drv(3'b000, 16'd0, 16'd0, 16'd0);
    tick();
    clear = 1'b0;
  endtask

  // Sends one full skewed row starting in the current cycle and returns in the
  // cycle its aligned vector should be visible.
  task automatic send_row(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    drv(3'b100, a, 16'd0, 16'd0); tick();
    drv(3'b010, 16'd0, b, 16'd0); tick();
    drv(3'b001, 16'd0, 16'd0, c); tick();
    drv(3'b000, 16'd0, 16'd0, 16'd0);
  endtask

  initial begin
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    in_valid2 = '0;
    in_data2  = '0;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data",  64'(out_data), 64'd0);
    chk("rst_fd",    64'(frame_done), 64'd0);
    chk("rst_idx",   64'(row_index), 64'd0);
    chk("rst_err",   64'(misalign_err), 64'd0);
    chk("rst_valid2", 64'(out_valid2), 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // Single skewed row (10,20,30): visible in cycle 3, not before.
    drv(3'b100, 16'd10, 16'd0, 16'd0); tick();
    drv(3'b010, 16'd0, 16'd20, 16'd0); tick();
    chk("lat_early", 64'(out_valid), 64'd0);
    drv(3'b001, 16'd0, 16'd0, 16'd30); tick();
    chk_row("r10", 16'd10, 16'd20, 16'd30, 2'd0, 1'b0);
    drv(3'b000, 16'd0, 16'd0, 16'd0);
    clear_pulse();

    // Back-to-back rows, frame wrap.
    drv(3'b100, 16'd1, 16'd0, 16'd0);   tick();
    drv(3'b110, 16'd4, 16'd2, 16'd0);   tick();
    drv(3'b111, 16'd7, 16'd5, 16'd3);   tick();
    chk_row("b0", 16'd1, 16'd2, 16'd3, 2'd0, 1'b0);
    drv(3'b111, 16'd10, 16'd8, 16'd6);  tick();
    chk_row("b1", 16'd4, 16'd5, 16'd6, 2'd1, 1'b0);
    drv(3'b111, 16'd13, 16'd11, 16'd9); tick();
    chk_row("b2", 16'd7, 16'd8, 16'd9, 2'd2, 1'b0);
    drv(3'b011, 16'd0, 16'd14, 16'd12); tick();
    chk_row("b3", 16'd10, 16'd11, 16'd12, 2'd3, 1'b1);
    drv(3'b001, 16'd0, 16'd0, 16'd15);  tick();
    chk_row("b4", 16'd13, 16'd14, 16'd15, 2'd0, 1'b0);
    drv(3'b000, 16'd0, 16'd0, 16'd0);   tick();
    chk("hold_valid", 64'(out_valid), 64'd0);
    chk("hold_data",  64'(out_data), 64'({16'd13, 16'd14, 16'd15}));
    chk("hold_err",   64'(misalign_err), 64'd0);
    clear_pulse();

    // Lane 2 valid withheld: row dropped, sticky error.
    drv(3'b100, 16'd41, 16'd0, 16'd0); tick();
    drv(3'b010, 16'd0, 16'd42, 16'd0); tick();
    drv(3'b000, 16'd0, 16'd0, 16'd43); tick();
    chk("mis_valid", 64'(out_valid), 64'd0);
    chk("mis_err",   64'(misalign_err), 64'd1);
    send_row(16'd50, 16'd51, 16'd52);
    chk_row("mis_next", 16'd50, 16'd51, 16'd52, 2'd0, 1'b0);
    chk("mis_sticky", 64'(misalign_err), 64'd1);
    tick();

    // Clear mid-row: lane 0 in flight and lane 1 on the clear cycle are lost.
    drv(3'b100, 16'd70, 16'd0, 16'd0); tick();
    clear = 1'b1;
    drv(3'b010, 16'd0, 16'd80, 16'd0); tick();
    clear = 1'b0;
    drv(3'b000, 16'd0, 16'd0, 16'd0);  tick();
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_err",   64'(misalign_err), 64'd0);
    send_row(16'd60, 16'd61, 16'd62);
    chk_row("clr_next", 16'd60, 16'd61, 16'd62, 2'd0, 1'b0);
    tick();

    // Clear on the cycle a row aligns: nothing emitted, count reset.
    drv(3'b100, 16'd90, 16'd0, 16'd0); tick();
    drv(3'b010, 16'd0, 16'd91, 16'd0); tick();
    clear = 1'b1;
    drv(3'b001, 16'd0, 16'd0, 16'd92); tick();
    clear = 1'b0;
    drv(3'b000, 16'd0, 16'd0, 16'd0);
    chk("clrwin_valid", 64'(out_valid), 64'd0);
    chk("clrwin_data",  64'(out_data), 64'({16'd60, 16'd61, 16'd62}));
    chk("clrwin_err",   64'(misalign_err), 64'd0);

    // Async reset pulse between edges while out_valid is high.
    send_row(16'd21, 16'd22, 16'd23);
    chk_row("pre_rst", 16'd21, 16'd22, 16'd23, 2'd0, 1'b0);
    send_row(16'd24, 16'd25, 16'd26);
    chk_row("pre_rst2", 16'd24, 16'd25, 16'd26, 2'd1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data",  64'(out_data), 64'd0);
    chk("arst_idx",   64'(row_index), 64'd0);
    #1;
    reset = 1'b0;
    send_row(16'd31, 16'd32, 16'd33);
    chk_row("post_rst", 16'd31, 16'd32, 16'd33, 2'd0, 1'b0);
    chk("post_rst_err", 64'(misalign_err), 64'd0);
    tick();

    // size=2, rows=1 instance: latency 2, frame_done with every row.
    in_valid2 = 2'b10; in_data2 = {16'd5, 16'd0}; tick();
    chk("s2_early", 64'(out_valid2), 64'd0);
    in_valid2 = 2'b01; in_data2 = {16'd0, 16'd6}; tick();
    in_valid2 = 2'b00; in_data2 = '0;
    chk("s2_valid", 64'(out_valid2), 64'd1);
    chk("s2_data",  64'(out_data2), 64'({16'd5, 16'd6}));
    chk("s2_fd",    64'(frame_done2), 64'd1);
    chk("s2_idx",   64'(row_index2), 64'd0);
    $display("[TB] row s2: data=%0h fd=%0b", out_data2, frame_done2);
    tick();
    chk("s2_fd_off", 64'(frame_done2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/deskew_collector.md
# deskew_collector

Output-side de-skew stage for the backprop systolic stack. It sits directly downstream of the systolic array that consumes the diagonally skewed vectors produced by the input skew stage. It receives per-lane results that emerge one cycle apart, lane by lane, and delays each lane so that every row is realigned into one parallel vector. It also counts rows into frames and flags lane-valid misalignment.

## Interface
Parameters:
- data_size, 16, width of one lane element in bits.
- size, 3, number of lanes; must be ≥ 2.
- rows, 4, number of aligned vectors per frame; must be ≥ 1.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- clear  input  1  synchronous flush of delay lines, row counter and error flag.
- in_valid  input  size  per-lane valid; bit (size-1-k) belongs to lane k.
- in_data  input  data_size*size  lane k occupies slice [data_size*(size-k)-1 -: data_size]; lane 0 is the MSB slice.
- out_valid  output  1  aligned vector present on out_data.
- out_data  output  data_size*size  aligned vector, same lane packing as in_data.
- frame_done  output  1  one-cycle pulse coincident with out_valid for the last row of a frame.
- row_index  output  $clog2(rows) (min 1)  index of the row currently on out_data.
- misalign_err  output  1  sticky error flag.

## Operation
- Input contract: for row r, lane k (data and valid) arrives at cycle t_r + k. Lane 0 is earliest, lane size-1 is latest.
- Lane k passes through a (size-1-k)-stage delay line carrying {valid, data}. Lane size-1 has zero stages. Each stage is a plain register with no enable; it shifts every cycle.
- Aligned set: every lane's delay-line output (lane size-1 taken directly from the input).
- Aligned valid all 1:
  - out_data is registered from the aligned data and out_valid = 1.
  - row_index takes the current row count. The row count then increments and wraps from rows-1 to 0.
  - frame_done = 1 when the emitted row count equals rows-1.
- Aligned valid all 0: out_valid = 0, and out_data holds its last value.
- Aligned valid mixed (some lanes 1, some 0):
  - The vector is dropped: out_valid = 0 and the row count does not advance.
  - misalign_err is set to 1 and stays set until reset or clear.
- clear = 1:
  - Next edge zeroes all delay stages, out_valid, frame_done, the row count and misalign_err.
  - Data in flight is discarded. Inputs on the clear cycle are ignored.
- No backpressure: the array cannot stall, so a valid vector is always accepted.
- Reset values: out_valid = 0, out_data = 0, frame_done = 0, row_index = 0, misalign_err = 0, all delay stages = 0.

## Timing
- Latency: lane 0 of row r at cycle t produces out_valid at edge t+size, i.e. visible in cycle t+size. The last lane arrives at t+size-1, so the output appears one cycle after it.
- Throughput: one row per cycle. Back-to-back rows (t_{r+1} = t_r + 1) produce consecutive out_valid cycles.
- Wrap: row_index sequence is 0..rows-1, 0, …. frame_done fires on each row_index = rows-1.
- Clear during a partial frame: the next valid row is emitted with row_index 0.
- Reset mid-operation:
  - Outputs go to reset values immediately (asynchronously).
  - Rows partially in the delay lines are lost, with no error raised.
  - The first row fully presented after deassertion is emitted normally.
- Simultaneous clear and a completing aligned row: clear wins, and nothing is emitted.
- rows = 1: frame_done pulses with every out_valid.

## Structure
- A shared package (backprop_pkg) holds the lane slicing function lane(vec, k) returning [data_size*(size-k)-1 -: data_size], and the row-count width helper.
- Sub-module lane_delay (parameters data_size, depth): a depth-stage {valid, data} shift register with async reset and sync clear. depth = 0 is a pass-through. It is instantiated size times in a generate loop with depth = size-1-k.
- Top level contains the alignment check, output register, row counter and error flag.

## Test plan
- size=3, rows=4, skewed row with lane data 10, 20, 30 starting at cycle 0 (valids 100, 010, 001 on cycles 0, 1, 2) -> out_valid in cycle 3 with lanes 10, 20, 30 and row_index 0.
- Four back-to-back skewed rows (1,2,3), (4,5,6), (7,8,9), (10,11,12) -> out_valid high cycles 3–6 with row_index 0,1,2,3; frame_done only in cycle 6; fifth row gives row_index 0.
- Lane 2 valid withheld for row 0 -> no out_valid in cycle 3, misalign_err = 1 and stays set; the next good row is emitted with row_index 0.
- clear asserted in cycle 1 mid-row -> no output in cycle 3, misalign_err = 0, row count 0; a subsequent row is emitted normally.
- Async reset pulse between edges while out_valid = 1 -> out_valid, out_data and row_index drop to 0 before the next edge; recovery with a fresh row.
- size=2, rows=1 instance: row (5,6) -> out_valid with frame_done at latency 2.
